seven_segment_scan_scheduler: RTL



---
 rtl/seven_segment_scan_scheduler_if.sv | 24 ++
 rtl/seven_segment_scan_scheduler.sv | 131 +++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_scheduler_if.sv
// Write port of the seven-segment scan scheduler: BCD digit codes plus decimal points, valid/ready.
// The master is the number producer; the slave is the scheduler, which holds off writes while one is pending.
interface seven_segment_scan_scheduler_if #(
  parameter int N_DIGITS = 3
) ();
  logic                  wr_valid;
  logic                  wr_ready;
  logic [4*N_DIGITS-1:0] wr_value;
  logic [N_DIGITS-1:0]   wr_dp;

  modport master (
    output wr_valid,
    output wr_value,
    output wr_dp,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_value,
    input  wr_dp,
    output wr_ready
  );
endinterface

// File: rtl/seven_segment_scan_scheduler.sv
// Time-multiplexed seven-segment scan: one digit lit per slot after a blanking gap; registered outputs.
// Writes land in a shadow register (wr_ready low while pending) and are committed only at the frame wrap.
module seven_segment_scan_scheduler #(
  parameter int N_DIGITS     = 3,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  seven_segment_scan_scheduler_if.slave wr,
  output logic [N_DIGITS-1:0]           dig_en_o,
  output logic [7:0]                    seg_o,
  output logic                          slot_tick_o,
  output logic                          frame_tick_o
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } phase_e;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  phase_e                phase_q, phase_d;
  logic [4*N_DIGITS-1:0] active_val_q, shadow_val_q;
  logic [N_DIGITS-1:0]   active_dp_q, shadow_dp_q;
  logic                  pending_q;
  logic [N_DIGITS-1:0]   dig_en_q;
  logic [7:0]            seg_q;
  logic                  slot_tick_q, frame_tick_q;

  logic                  cnt_last, frame_wrap, accept;
  logic [N_DIGITS-1:0]   en_d;
  logic [3:0]            digit_d;
  logic                  dp_d;

  // Everything registered below is driven from next-state values, so outputs line up with cnt/idx of their cycle.
  always_comb begin
    cnt_last   = (cnt_q == CNT_LAST);
    frame_wrap = cnt_last && (idx_q == IDX_LAST);
    accept     = wr.wr_valid && !pending_q;
    cnt_d      = cnt_last ? '0 : cnt_q + CW'(1);
    idx_d      = idx_q;
    if (cnt_last) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    phase_d = phase_q;
    case (phase_q)
      BLANK:   if (cnt_d == CNT_SHOW) phase_d = SHOW;
      SHOW:    if (cnt_last) phase_d = BLANK;
      default: phase_d = BLANK;
    endcase
    en_d    = '0;
    digit_d = 4'hF;
    dp_d    = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        en_d[i] = 1'b1;
        digit_d = active_val_q[4*i +: 4];
        dp_d    = active_dp_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      phase_q      <= BLANK;
      active_val_q <= '1;
      active_dp_q  <= '0;
      shadow_val_q <= '1;
      shadow_dp_q  <= '0;
      pending_q    <= 1'b0;
      dig_en_q     <= '0;
      seg_q        <= 8'hFF;
      slot_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      if (accept) begin
        shadow_val_q <= wr.wr_value;
        shadow_dp_q  <= wr.wr_dp;
        pending_q    <= 1'b1;
      end
      // A write accepted on the wrap edge sees pending_q=0 here, so it waits for the next wrap.
      if (frame_wrap && pending_q) begin
        active_val_q <= shadow_val_q;
        active_dp_q  <= shadow_dp_q;
        pending_q    <= 1'b0;
      end
      slot_tick_q  <= cnt_last;
      frame_tick_q <= frame_wrap;
      dig_en_q     <= (phase_d == SHOW) ? en_d : '0;
      seg_q        <= (phase_d == SHOW) ? {decode(digit_d), ~dp_d} : 8'hFF;
    end
  end

  assign wr.wr_ready   = ~pending_q;
  assign dig_en_o      = dig_en_q;
  assign seg_o         = seg_q;
  assign slot_tick_o   = slot_tick_q;
  assign frame_tick_o  = frame_tick_q;

endmodule
